// File: rtl/alu_pkg.sv
// Shared ALU encodings for the ALU-control sequencer: ALU operation codes,
// R-type funct values, alu_op classes and the sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_DIV = 4'b1011;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_SLTI   = 2'b11;

  // Selects which latency a long op uses.
  localparam logic LAT_MULT = 1'b0;
  localparam logic LAT_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LONG = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational decode of alu_op/funct into the ALU control code, an illegal
// flag, and whether the op is a multi-cycle one (and which latency applies).
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       illegal,
  output logic       is_long,
  output logic       lat_sel
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    is_long     = 1'b0;
    lat_sel     = LAT_MULT;
    unique case (alu_op)
      ALUOP_MEM:    alu_control = ALU_ADD;
      ALUOP_BRANCH: alu_control = ALU_SUB;
      ALUOP_SLTI:   alu_control = ALU_SLT;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  alu_control = ALU_ADD;
          FUNCT_SUB:  alu_control = ALU_SUB;
          FUNCT_AND:  alu_control = ALU_AND;
          FUNCT_OR:   alu_control = ALU_OR;
          FUNCT_XOR:  alu_control = ALU_XOR;
          FUNCT_NOR:  alu_control = ALU_NOR;
          FUNCT_SLT:  alu_control = ALU_SLT;
          FUNCT_SLL:  alu_control = ALU_SLL;
          FUNCT_SRL:  alu_control = ALU_SRL;
          FUNCT_SRA:  alu_control = ALU_SRA;
          FUNCT_MULT: begin
            alu_control = ALU_MUL;
            is_long     = 1'b1;
            lat_sel     = LAT_MULT;
          end
          FUNCT_DIV: begin
            alu_control = ALU_DIV;
            is_long     = 1'b1;
            lat_sel     = LAT_DIV;
          end
          // Unknown funct issues as a harmless add, flagged for the consumer.
          default: illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU-control sequencer: registers decoded alu_control behind a valid/ready
// handshake and stalls for MULT/DIV latency. Define ALU_CTRL_STATS_EN for counters.
module alu_ctrl_seq
  import alu_pkg::*;
#(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_control,
  output logic       illegal,
  output logic       busy
`ifdef ALU_CTRL_STATS_EN
  ,
  output logic [15:0] op_count,
  output logic [15:0] illegal_count
`endif
);

  // Counter preload is LAT-2: the accept edge and the LONG->HOLD edge each
  // account for one cycle. A latency of 1 skips LONG entirely.
  localparam logic MULT_MULTI = (MULT_LAT > 1);
  localparam logic DIV_MULTI  = (DIV_LAT > 1);
  localparam logic [CNT_W-1:0] MULT_INIT = CNT_W'((MULT_LAT > 1) ? MULT_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       ctrl_next;
  logic             illegal_next;
  logic             load;

  logic [3:0]       dec_ctrl;
  logic             dec_illegal;
  logic             dec_long;
  logic             dec_lat_sel;
  logic             dec_multi;
  logic [CNT_W-1:0] dec_init;
  logic             accept;

  alu_funct_decode u_decode (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (dec_ctrl),
    .illegal     (dec_illegal),
    .is_long     (dec_long),
    .lat_sel     (dec_lat_sel)
  );

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign busy      = (state == LONG);

  assign dec_multi = dec_long && ((dec_lat_sel == LAT_DIV) ? DIV_MULTI : MULT_MULTI);
  assign dec_init  = (dec_lat_sel == LAT_DIV) ? DIV_INIT : MULT_INIT;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    ctrl_next    = alu_control;
    illegal_next = illegal;
    load         = 1'b0;
    unique case (state)
      IDLE: load = accept;
      LONG: begin
        if (cnt == '0) state_next = HOLD;
        else           cnt_next   = cnt - CNT_ONE;
      end
      HOLD: begin
        if (out_ready) begin
          load = accept;
          if (!accept) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new op loads identically from IDLE or from a completing HOLD.
    if (load) begin
      ctrl_next    = dec_ctrl;
      illegal_next = dec_illegal;
      if (dec_multi) begin
        state_next = LONG;
        cnt_next   = dec_init;
      end else begin
        state_next = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_control <= ALU_ADD;
      illegal     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_next;
      cnt         <= cnt_next;
      alu_control <= ctrl_next;
      illegal     <= illegal_next;
    end
  end

`ifdef ALU_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count      <= '0;
      illegal_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 16'd1;
      if (illegal) illegal_count <= illegal_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed latency/handshake scenarios
// plus a randomized op stream checked through an expected-result queue.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] funct = 6'b000000;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] alu_control;
  logic       illegal;
  logic       busy;
`ifdef ALU_CTRL_STATS_EN
  logic [15:0] op_count;
  logic [15:0] illegal_count;
`endif

  int total = 0;
  int bad   = 0;
  int exp_ops = 0;
  int exp_ill = 0;
  logic [4:0] sb[$];

  alu_ctrl_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct       (funct),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_control (alu_control),
    .illegal     (illegal),
    .busy        (busy)
`ifdef ALU_CTRL_STATS_EN
    ,
    .op_count      (op_count),
    .illegal_count (illegal_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode: {illegal, alu_control}.
  function automatic logic [4:0] model(input logic [1:0] op, input logic [5:0] f);
    logic [4:0] r;
    case (op)
      2'b00: r = 5'b0_0010;
      2'b01: r = 5'b0_0110;
      2'b11: r = 5'b0_0111;
      default: begin
        case (f)
          6'b100000: r = 5'b0_0010;
          6'b100010: r = 5'b0_0110;
          6'b100100: r = 5'b0_0000;
          6'b100101: r = 5'b0_0001;
          6'b100110: r = 5'b0_0100;
          6'b100111: r = 5'b0_1100;
          6'b101010: r = 5'b0_0111;
          6'b000000: r = 5'b0_1000;
          6'b000010: r = 5'b0_1001;
          6'b000011: r = 5'b0_1010;
          6'b011000: r = 5'b0_0101;
          6'b011010: r = 5'b0_1011;
          default:   r = 5'b1_0010;
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Inputs change at posedge+1, checks at posedge+2, so negedge sees settled values.
  task automatic monitor();
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_ops = 0;
        exp_ill = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_output", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("sb_result", 32'({illegal, alu_control}), 32'(e));
            exp_ops++;
            if (e[4]) exp_ill++;
          end
        end
        if (in_valid && in_ready) sb.push_back(model(alu_op, funct));
      end
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] f);
    int  waited;
    bit  done;
    waited   = 0;
    done     = 1'b0;
    alu_op   = op;
    funct    = f;
    in_valid = 1'b1;
    while (!done) begin
      out_ready = ($urandom_range(3) != 0);
      #1;
      done = in_ready;
      cyc();
      waited++;
      if (!done && waited > 40) begin
        check("send_timeout", 32'(waited), 32'd40);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  localparam int NF = 14;
  logic [5:0] functs [NF] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100110, 6'b100111, 6'b101010, 6'b000000,
                              6'b000010, 6'b000011, 6'b011000, 6'b011010,
                              6'b111111, 6'b010101};

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int   waited;
    logic [5:0] f;
    logic [1:0] op;

    fork
      monitor();
    join_none

    // Reset state.
    repeat (2) cyc();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ctrl", 32'(alu_control), 32'h2);
    check("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    cyc();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back short ops at full throughput.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_op    = 2'b10;
    funct     = 6'b100100;
    #1 check("b2b_ready0", 32'(in_ready), 32'd1);
    cyc();
    funct = 6'b100111;
    #1;
    check("b2b_ctrl0", 32'(alu_control), 32'h0);
    check("b2b_valid0", 32'(out_valid), 32'd1);
    check("b2b_ready1", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    #1;
    check("b2b_ctrl1", 32'(alu_control), 32'hc);
    check("b2b_valid1", 32'(out_valid), 32'd1);
    cyc();
    #1;
    check("b2b_idle_valid", 32'(out_valid), 32'd0);
    check("b2b_idle_ctrl_hold", 32'(alu_control), 32'hc);

    // MULT latency.
    in_valid = 1'b1;
    funct    = 6'b011000;
    #1 check("mult_accept_ready", 32'(in_ready), 32'd1);
    for (int n = 1; n <= 6; n++) begin
      cyc();
      in_valid = 1'b0;
      #1;
      check($sformatf("mult_busy_c%0d", n), 32'(busy), 32'(n <= 3));
      check($sformatf("mult_valid_c%0d", n), 32'(out_valid), 32'(n == 4));
      check($sformatf("mult_ready_c%0d", n), 32'(in_ready), 32'(!(n >= 1 && n <= 3)));
      if (n == 4) check("mult_ctrl", 32'(alu_control), 32'h5);
    end

    // DIV with backpressure until cycle 20.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    funct     = 6'b011010;
    for (int n = 1; n <= 22; n++) begin
      cyc();
      in_valid  = 1'b0;
      out_ready = (n == 20);
      #1;
      check($sformatf("div_valid_c%0d", n), 32'(out_valid), 32'(n >= 16 && n <= 20));
      check($sformatf("div_busy_c%0d", n), 32'(busy), 32'(n <= 15));
      check($sformatf("div_ready_c%0d", n), 32'(in_ready), 32'(n >= 20));
      if (n >= 16 && n <= 20) check($sformatf("div_ctrl_c%0d", n), 32'(alu_control), 32'hb);
    end

    // Illegal funct, then a legal op clears the flag.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_op    = 2'b10;
    funct     = 6'b111111;
    #1;
`ifdef ALU_CTRL_STATS_EN
    check("stats_ill_before", 32'(illegal_count), 32'd0);
`endif
    cyc();
    funct = 6'b100000;
    #1;
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_ctrl", 32'(alu_control), 32'h2);
    check("ill_valid", 32'(out_valid), 32'd1);
    cyc();
    in_valid = 1'b0;
    #1;
    check("ill_cleared", 32'(illegal), 32'd0);
    check("ill_next_valid", 32'(out_valid), 32'd1);
`ifdef ALU_CTRL_STATS_EN
    check("stats_ill_after", 32'(illegal_count), 32'd1);
`endif
    cyc();

    // Reset in the middle of a DIV.
    in_valid = 1'b1;
    funct    = 6'b011010;
    for (int n = 1; n <= 5; n++) begin
      cyc();
      in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ctrl", 32'(alu_control), 32'h2);
    cyc();
    cyc();
    rst_n = 1'b1;
    #1 check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int n = 0; n < 20; n++) begin
      cyc();
      check($sformatf("midrst_no_valid_%0d", n), 32'(out_valid), 32'd0);
    end
    alu_op   = 2'b11;
    funct    = 6'b000000;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1;
    check("slti_ctrl", 32'(alu_control), 32'h7);
    check("slti_valid", 32'(out_valid), 32'd1);
    cyc();

    // Randomized stream with random backpressure.
    for (int i = 0; i < 60; i++) begin
      f = functs[$urandom_range(NF - 1)];
      if ((f == 6'b011000 || f == 6'b011010) && $urandom_range(2) != 0) f = 6'b100000;
      op = 2'b10;
      if ($urandom_range(3) == 0) begin
        op = 2'($urandom_range(2));
        if (op == 2'b10) op = 2'b11;
      end
      send(op, f);
      if ($urandom_range(3) == 0) cyc();
    end

    // Drain everything still in flight.
    out_ready = 1'b1;
    waited    = 0;
    while ((sb.size() != 0 || out_valid) && waited < 60) begin
      cyc();
      waited++;
    end
    cyc();
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("drain_idle", 32'(out_valid), 32'd0);
`ifdef ALU_CTRL_STATS_EN
    check("stats_ops", 32'(op_count), 32'(exp_ops));
    check("stats_ill", 32'(illegal_count), 32'(exp_ill));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
